// File: rtl/vec_frame_mem.sv
// Double-buffered vector frame memory: CPU read/write port plus a VGA streamer that
// prefetches the front framebuffer into a show-ahead FIFO. Buffer swaps apply at frame start.
module vec_frame_mem #(
  parameter int N           = 8,
  parameter int R           = 6,
  parameter int I           = 32,
  parameter int DEPTH       = 10930,
  parameter int FRAME_WORDS = 5400,
  parameter int FB0_BASE    = 0,
  parameter int FB1_BASE    = 5400,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cpu_we,
  input  logic [I-1:0]     i_cpu_addr,
  input  logic [R*N-1:0]   i_cpu_wd,
  output logic [R*N-1:0]   o_cpu_rd,
  output logic             o_cpu_addr_err,
  input  logic             i_swap_req,
  output logic             o_swap_pending,
  output logic             o_swap_done,
  output logic             o_front_sel,
  input  logic             i_vga_frame_start,
  input  logic             i_vga_rd_en,
  output logic [R*N-1:0]   o_vga_data,
  output logic             o_vga_empty,
  output logic             o_vga_underrun,
  output logic [1:0]       o_dbg_state
);

  localparam int W  = R * N;
  localparam int AW = $clog2(DEPTH);
  localparam int RW = $clog2(FRAME_WORDS + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [I-1:0]  DEPTH_I = I'(DEPTH);
  localparam logic [AW-1:0] FB0_A   = AW'(FB0_BASE);
  localparam logic [AW-1:0] FB1_A   = AW'(FB1_BASE);
  localparam logic [RW-1:0] FRAME_R = RW'(FRAME_WORDS);
  localparam logic [CW-1:0] FIFO_C  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  logic [W-1:0]  r_mem [DEPTH];
  logic [W-1:0]  r_cpu_rd_raw;
  logic          r_cpu_rd_ok;
  logic          r_addr_err;
  logic          r_swap_pending;
  logic          r_swap_done;
  logic          r_front_sel;
  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_fetch_addr;
  logic [RW-1:0] r_remaining;
  logic          r_inflight;
  logic [W-1:0]  r_rdb_data;
  logic [W-1:0]  r_fifo [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_underrun;

  logic          w_cpu_in_range;
  logic [AW-1:0] w_cpu_idx;
  logic          w_swap_want;
  logic [AW-1:0] w_front_base;
  logic          w_can_issue;
  logic          w_issue;
  logic          w_fifo_empty;
  logic          w_push;
  logic          w_pop;

  assign w_cpu_in_range = (i_cpu_addr < DEPTH_I);
  assign w_cpu_idx      = w_cpu_in_range ? i_cpu_addr[AW-1:0] : '0;

  // A swap requested in the same cycle as frame start still applies to that frame.
  assign w_swap_want  = r_swap_pending | i_swap_req;
  assign w_front_base = (r_front_sel ^ w_swap_want) ? FB1_A : FB0_A;

  // Handshake: o_vga_data is the show-ahead head, valid while !o_vga_empty; i_vga_rd_en
  // consumes it on the clock edge. Popping an empty FIFO is ignored and flagged in
  // o_vga_underrun. Issue gating counts the in-flight read, so the FIFO never overflows.
  assign w_fifo_empty = (r_count == '0);
  assign w_can_issue  = ((r_count + CW'(r_inflight)) < FIFO_C);
  assign w_push       = r_inflight & ~i_vga_frame_start;
  assign w_pop        = i_vga_rd_en & ~w_fifo_empty & ~i_vga_frame_start;

  // Array: no reset; read-before-write gives old data on same-address access.
  always_ff @(posedge i_clk) begin
    if (i_cpu_we && w_cpu_in_range) r_mem[w_cpu_idx] <= i_cpu_wd;
    r_cpu_rd_raw <= r_mem[w_cpu_idx];
    if (w_issue) r_rdb_data <= r_mem[r_fetch_addr];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cpu_rd_ok    <= 1'b0;
      r_addr_err     <= 1'b0;
      r_swap_pending <= 1'b0;
      r_swap_done    <= 1'b0;
      r_front_sel    <= 1'b0;
    end else begin
      r_cpu_rd_ok <= w_cpu_in_range;
      if (!w_cpu_in_range) r_addr_err <= 1'b1;
      if (i_vga_frame_start) begin
        r_swap_pending <= 1'b0;
        r_swap_done    <= w_swap_want;
        if (w_swap_want) r_front_sel <= ~r_front_sel;
      end else begin
        r_swap_done <= 1'b0;
        if (i_swap_req) r_swap_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    if (i_vga_frame_start) begin
      w_state_nxt = S_FETCH;
    end else begin
      unique case (r_state)
        S_IDLE:  w_state_nxt = S_IDLE;
        S_FETCH: begin
          if ((r_remaining != '0) && w_can_issue) begin
            w_issue = 1'b1;
            if (r_remaining == RW'(1)) w_state_nxt = S_DONE;
          end
        end
        S_DONE:  w_state_nxt = S_DONE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fetch_addr <= '0;
      r_remaining  <= '0;
      r_inflight   <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (i_vga_frame_start) begin
        r_fetch_addr <= w_front_base;
        r_remaining  <= FRAME_R;
      end else if (w_issue) begin
        r_fetch_addr <= r_fetch_addr + AW'(1);
        r_remaining  <= r_remaining - RW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= r_rdb_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_underrun <= 1'b0;
    end else if (i_vga_frame_start) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_underrun <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (i_vga_rd_en && w_fifo_empty) r_underrun <= 1'b1;
    end
  end

  assign o_cpu_rd       = r_cpu_rd_ok ? r_cpu_rd_raw : '0;
  assign o_cpu_addr_err = r_addr_err;
  assign o_swap_pending = r_swap_pending;
  assign o_swap_done    = r_swap_done;
  assign o_front_sel    = r_front_sel;
  assign o_vga_data     = w_fifo_empty ? '0 : r_fifo[r_rd_ptr];
  assign o_vga_empty    = w_fifo_empty;
  assign o_vga_underrun = r_underrun;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_vec_frame_mem.sv
// Directed bench for vec_frame_mem: CPU port, swap timing and the VGA prefetch streamer,
// checked against a scoreboard queue of expected words.
module tb_vec_frame_mem;

  localparam int W           = 48;
  localparam int DEPTH       = 10930;
  localparam int FRAME_WORDS = 5400;
  localparam int FB1_BASE    = 5400;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cpu_we;
  logic [31:0]  cpu_addr;
  logic [W-1:0] cpu_wd;
  logic [W-1:0] cpu_rd;
  logic         cpu_addr_err;
  logic         swap_req;
  logic         swap_pending;
  logic         swap_done;
  logic         front_sel;
  logic         vga_frame_start;
  logic         vga_rd_en;
  logic [W-1:0] vga_data;
  logic         vga_empty;
  logic         vga_underrun;
  logic [1:0]   dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] model [int];

  always #5 clk = ~clk;

  vec_frame_mem dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_cpu_we          (cpu_we),
    .i_cpu_addr        (cpu_addr),
    .i_cpu_wd          (cpu_wd),
    .o_cpu_rd          (cpu_rd),
    .o_cpu_addr_err    (cpu_addr_err),
    .i_swap_req        (swap_req),
    .o_swap_pending    (swap_pending),
    .o_swap_done       (swap_done),
    .o_front_sel       (front_sel),
    .i_vga_frame_start (vga_frame_start),
    .i_vga_rd_en       (vga_rd_en),
    .o_vga_data        (vga_data),
    .o_vga_empty       (vga_empty),
    .o_vga_underrun    (vga_underrun),
    .o_dbg_state       (dbg_state)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One CPU cycle; the registered read result is compared one edge later.
  task automatic cpu_step(input logic we, input logic [31:0] addr, input logic [W-1:0] wd);
    bit known;
    known = (addr >= 32'(DEPTH)) || model.exists(int'(addr));
    cpu_we   = we;
    cpu_addr = addr;
    cpu_wd   = wd;
    if (addr >= 32'(DEPTH))  exp_q.push_back('0);
    else if (known)          exp_q.push_back(model[int'(addr)]);
    tick();
    if (we && addr < 32'(DEPTH)) model[int'(addr)] = wd;
    cpu_we = 1'b0;
    if (known) chk("cpu_rd", cpu_rd, exp_q.pop_front());
  endtask

  task automatic frame_pulse();
    vga_frame_start = 1'b1;
    tick();
    vga_frame_start = 1'b0;
  endtask

  task automatic swap_pulse();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
  endtask

  // Pops n words as they become valid; the first nchk are compared against exp_q.
  task automatic pop_n(input int n, input int nchk, input string tag);
    int pops = 0;
    int cyc  = 0;
    while (pops < n && cyc < n + 200) begin
      vga_rd_en = !vga_empty;
      if (vga_rd_en) begin
        if (pops < nchk) chk(tag, vga_data, exp_q.pop_front());
        pops++;
      end
      tick();
      cyc++;
    end
    vga_rd_en = 1'b0;
    chk({tag, "_count"}, W'(pops), W'(n));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wd = '0;
    swap_req = 1'b0; vga_frame_start = 1'b0; vga_rd_en = 1'b0;
    repeat (3) tick();
    chk("rst_vga_empty", W'(vga_empty), W'(1));
    chk("rst_front_sel", W'(front_sel), W'(0));
    chk("rst_cpu_rd", cpu_rd, '0);
    chk("rst_addr_err", W'(cpu_addr_err), W'(0));
    chk("rst_swap_pending", W'(swap_pending), W'(0));
    chk("rst_swap_done", W'(swap_done), W'(0));
    chk("rst_underrun", W'(vga_underrun), W'(0));
    chk("rst_vga_data", vga_data, '0);
    chk("rst_state", W'(dbg_state), W'(0));
    rst_n = 1'b1;
    tick();

    // Framebuffer seeds: FB0[0..3]=1..4, FB1[0..3]=0x11..0x14.
    for (int i = 0; i < 4; i++) cpu_step(1'b1, 32'(i), W'(i + 1));
    for (int i = 0; i < 4; i++) cpu_step(1'b1, 32'(FB1_BASE + i), W'(16'h11 + i));

    cpu_step(1'b1, 32'd5, 48'h0605_0403_0201);
    cpu_step(1'b0, 32'd5, '0);
    cpu_step(1'b1, 32'd5, 48'hAABB_CCDD_EEFF);
    cpu_step(1'b0, 32'd5, '0);
    chk("addr_err_clear", W'(cpu_addr_err), W'(0));

    cpu_step(1'b1, 32'(DEPTH), 48'hDEAD_BEEF_0000);
    chk("addr_err_set", W'(cpu_addr_err), W'(1));
    cpu_step(1'b0, 32'd0, '0);
    cpu_step(1'b0, 32'd3, '0);
    chk("addr_err_sticky", W'(cpu_addr_err), W'(1));

    // Frame from FB0 with latency checks, then drain the whole frame.
    for (int i = 0; i < 4; i++) exp_q.push_back(W'(i + 1));
    frame_pulse();
    chk("f0_empty_t0", W'(vga_empty), W'(1));
    chk("f0_state_fetch", W'(dbg_state), W'(1));
    tick();
    chk("f0_empty_t1", W'(vga_empty), W'(1));
    tick();
    chk("f0_empty_t2", W'(vga_empty), W'(0));
    pop_n(FRAME_WORDS, 4, "f0_data");
    repeat (3) tick();
    chk("f0_end_empty", W'(vga_empty), W'(1));
    chk("f0_no_underrun", W'(vga_underrun), W'(0));
    chk("f0_state_done", W'(dbg_state), W'(2));

    vga_rd_en = 1'b1;
    tick();
    vga_rd_en = 1'b0;
    chk("underrun_set", W'(vga_underrun), W'(1));
    chk("underrun_data", vga_data, '0);

    // Swap requested mid-frame applies at the next frame start.
    frame_pulse();
    chk("underrun_cleared", W'(vga_underrun), W'(0));
    repeat (5) tick();
    swap_pulse();
    chk("swap_pending", W'(swap_pending), W'(1));
    chk("swap_front_hold", W'(front_sel), W'(0));
    chk("swap_no_done", W'(swap_done), W'(0));
    swap_pulse();
    chk("swap_pending_again", W'(swap_pending), W'(1));
    for (int i = 0; i < 4; i++) exp_q.push_back(W'(16'h11 + i));
    frame_pulse();
    chk("swap_front_sel", W'(front_sel), W'(1));
    chk("swap_pending_clr", W'(swap_pending), W'(0));
    chk("swap_done_pulse", W'(swap_done), W'(1));
    tick();
    chk("swap_done_low", W'(swap_done), W'(0));
    tick();
    chk("f1_empty_t2", W'(vga_empty), W'(0));
    pop_n(4, 4, "f1_data");

    // Consumer stalled: FIFO fills to capacity and the head stays put.
    for (int i = 0; i < 4; i++) exp_q.push_back(W'(16'h11 + i));
    frame_pulse();
    repeat (20) tick();
    chk("hold_state_fetch", W'(dbg_state), W'(1));
    chk("hold_head", vga_data, W'(16'h11));
    chk("hold_no_underrun", W'(vga_underrun), W'(0));
    pop_n(4, 4, "hold_data");

    // Reset mid-frame drops the pending swap and returns to FB0.
    swap_pulse();
    rst_n = 1'b0;
    tick();
    chk("mrst_front_sel", W'(front_sel), W'(0));
    chk("mrst_swap_pending", W'(swap_pending), W'(0));
    chk("mrst_empty", W'(vga_empty), W'(1));
    chk("mrst_state", W'(dbg_state), W'(0));
    chk("mrst_cpu_rd", cpu_rd, '0);
    rst_n = 1'b1;
    tick();
    exp_q.push_back(W'(1));
    frame_pulse();
    tick();
    tick();
    pop_n(1, 1, "post_rst_data");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
